sha256_compressor: RTL and testbench
====================================

Name: sha256_compressor

Overview:
- Downstream consumer of the message-schedule expander. Runs the 64 SHA-256 compression rounds for 4 independent message blocks, interleaved word-by-word in the same slot order the expander produces.
- Slot s = word index mod 4. Slot s consumes W0..W63 of its block as round words.
- At the end of each block it adds the working variables into the per-slot chaining hash and presents the 256-bit digest, one slot per cycle.

Parameters:
- SLOTS, 4, number of interleaved message streams; fixed at 4, with slot index width 2.
- ROUNDS, 64, compression rounds per block.

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  1-cycle pulse that begins a 4-slot block; honoured only in IDLE
- chain_i  in  1  sampled with start_i. 0: initialise every slot from the SHA-256 IV. 1: continue from each slot's stored H (next block of a multi-block message).
- w_valid_i  in  1  w_i is valid this cycle
- w_i  in  32  round word. The n-th accepted word (n = 0..255) is W[n>>2] for slot n&3.
- busy_o  out  1  high in ROUND and FINAL
- digest_valid_o  out  1  digest_o and digest_slot_o are valid
- digest_slot_o  out  2  slot that owns digest_o
- digest_o  out  256  H0..H7 of that slot, H0 in bits [255:224]

Behaviour:
- Reset (rst_i high at an edge): FSM goes to IDLE, word counter to 0, every output to 0, all per-slot H and a..h registers to 0. Reset dominates every other input, including mid-block. A block in flight is lost and no digest is emitted.
- State IDLE:
  - On start_i: load a..h of all 4 slots in one cycle, from the IV (chain_i=0) or from the slot's own H (chain_i=1).
  - With chain_i=0, H of each slot is also loaded with the IV.
  - Clear the 8-bit word counter cnt and go to ROUND.
  - w_valid_i is ignored in IDLE and in the start_i cycle. The first word is accepted on the cycle after start_i at the earliest.
- State ROUND:
  - On each cycle with w_valid_i=1: slot = cnt[1:0], round t = cnt[7:2].
  - Compute one full SHA-256 round on that slot's a..h using K[t] and w_i, write the result back the same edge, then cnt++.
  - Cycles with w_valid_i=0 hold all state; gaps of any length are legal.
  - When the word with cnt=255 is accepted, go to FINAL.
  - start_i is ignored while in ROUND.
- State FINAL: 4 cycles, f = 0..3.
  - Cycle f: H[f] <= H[f] + {a..h}[f], element-wise mod 2^32.
  - digest_o, digest_slot_o = f and digest_valid_o = 1 are registered and become visible the cycle after each add. The four valid cycles are therefore consecutive, in slot order 0,1,2,3.
  - w_valid_i and start_i are ignored in FINAL.
  - After f=3, go to IDLE. digest_valid_o drops the cycle after slot 3 was shown.
- busy_o is high from the cycle after start_i until the cycle after FINAL f=3 (registered).
- Latency: start_i to the first digest_valid_o is 256 + 2 cycles when w_valid_i is continuous.
- Arithmetic:
  - All additions are 32-bit and wrap; carries are discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22, Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g), Maj = (a&b)^(a&c)^(b&c).
  - T1 = h+Σ1+Ch+K+W, T2 = Σ0+Maj.
  - New a = T1+T2, new e = d+T1; the others shift (b=a, c=b, d=c, f=e, g=f, h=g).
- digest_o holds its last value when digest_valid_o=0; its reset value is 0.
- Per-slot H survives between blocks so that chain_i=1 works. Reset clears it.

Decomposition:
- Shared package holds:
  - the SHA-256 IV (8×32) and K table (64×32) constants;
  - the FSM state encoding IDLE/ROUND/FINAL;
  - SLOTS and the slot index width.
- One sub-module, sha256_k_rom: combinational 6-bit t → 32-bit K[t] lookup from the package table.
- The round function stays inline in this block.

Test Plan:
- "abc" padded block in all 4 slots, chain_i=0, continuous w_valid_i → 4 consecutive digests, slots 0..3, each ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. First digest valid exactly 258 cycles after start_i.
- Mixed slots:
  - stimulus: slot0 = empty message, slot1 = "abc", slots 2/3 = empty;
  - response: slot0 digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, and slot1 the "abc" value.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - stimulus: block 1 with chain_i=0, then block 2 with chain_i=1;
  - response: second-pass digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Random w_valid_i gaps (about 30% idle) with the "abc" stimulus → identical digests, and no state change on idle cycles.
- start_i pulsed at cnt=100 and again during FINAL → ignored; digests unchanged; busy_o stays high.
- rst_i asserted at cnt=137 → the next cycle shows busy_o=0, digest_valid_o=0, digest_o=0. A fresh "abc" block then yields the correct digest.

Source files
------------

// File: rtl/sha256_compressor_pkg.sv
// sha256_compressor_pkg: SHA-256 constants, FSM encoding and round helpers
package sha256_compressor_pkg;
   localparam int SLOTS  = 4;
   localparam int SLOT_W = 2;
   localparam int ROUNDS = 64;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   // Element 0 is a (or H0) and sits in the most significant 32 bits.
   typedef logic [0:7][31:0] vars_t;
   localparam vars_t IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [0:ROUNDS-1][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
endpackage

// File: rtl/sha256_compressor_if.sv
// sha256_compressor_if: word stream in, digest stream out
interface sha256_compressor_if;
   logic         start_i;
   logic         chain_i;
   logic         w_valid_i;
   logic [31:0]  w_i;
   logic         busy_o;
   logic         digest_valid_o;
   logic [1:0]   digest_slot_o;
   logic [255:0] digest_o;
   modport master (
      output start_i, chain_i, w_valid_i, w_i,
      input  busy_o, digest_valid_o, digest_slot_o, digest_o
   );
   modport slave (
      input  start_i, chain_i, w_valid_i, w_i,
      output busy_o, digest_valid_o, digest_slot_o, digest_o
   );
endinterface

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: combinational round-constant lookup
module sha256_k_rom
   import sha256_compressor_pkg::*;
(
   input  logic [5:0]  i_t,
   output logic [31:0] o_k
);
   assign o_k = K[i_t];
endmodule

// File: rtl/sha256_compressor.sv
// sha256_compressor: 64-round SHA-256 compression over 4 word-interleaved slots
module sha256_compressor
   import sha256_compressor_pkg::*;
(
   input logic                clk_i,
   input logic                rst_i,
   sha256_compressor_if.slave bus
);
   logic [1:0]        r_state;
   logic [7:0]        r_cnt;
   logic [1:0]        r_f;
   logic              r_busy;
   logic              r_dv;
   logic [SLOT_W-1:0] r_dslot;
   vars_t             r_digest;
   vars_t             r_h [SLOTS];
   vars_t             r_v [SLOTS];
   logic [SLOT_W-1:0] w_slot;
   logic [31:0]       w_k;
   logic [31:0]       w_ch;
   logic [31:0]       w_maj;
   logic [31:0]       w_t1;
   logic [31:0]       w_t2;
   vars_t             w_cur;
   vars_t             w_next;
   vars_t             w_sum;

   assign w_slot = r_cnt[1:0];

   sha256_k_rom u_k_rom (.i_t(r_cnt[7:2]), .o_k(w_k));

   always_comb begin
      w_cur  = r_v[w_slot];
      w_ch   = (w_cur[4] & w_cur[5]) ^ (~w_cur[4] & w_cur[6]);
      w_maj  = (w_cur[0] & w_cur[1]) ^ (w_cur[0] & w_cur[2]) ^ (w_cur[1] & w_cur[2]);
      w_t1   = w_cur[7] + bsig1(w_cur[4]) + w_ch + w_k + bus.w_i;
      w_t2   = bsig0(w_cur[0]) + w_maj;
      w_next = {w_t1 + w_t2, w_cur[0], w_cur[1], w_cur[2], w_cur[3] + w_t1, w_cur[4], w_cur[5], w_cur[6]};
      w_sum  = '0;
      for (int j = 0; j < 8; j++) w_sum[j] = r_h[r_f][j] + r_v[r_f][j];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_f      <= '0;
         r_busy   <= 1'b0;
         r_dv     <= 1'b0;
         r_dslot  <= '0;
         r_digest <= '0;
         r_h      <= '{default: '0};
         r_v      <= '{default: '0};
      end else if (r_state == S_IDLE) begin
         r_dv <= 1'b0;
         if (bus.start_i) begin
            for (int s = 0; s < SLOTS; s++) begin
               r_v[s] <= bus.chain_i ? r_h[s] : IV;
               r_h[s] <= bus.chain_i ? r_h[s] : IV;
            end
            r_cnt   <= '0;
            r_f     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ROUND;
         end
      end else if (r_state == S_ROUND) begin
         if (bus.w_valid_i) begin
            r_v[w_slot] <= w_next;
            r_cnt       <= r_cnt + 8'd1;
            if (r_cnt == 8'hff) r_state <= S_FINAL;
         end
      end else begin
         r_h[r_f] <= w_sum;
         r_digest <= w_sum;
         r_dv     <= 1'b1;
         r_dslot  <= r_f;
         r_f      <= r_f + 2'd1;
         if (r_f == 2'd3) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
         end
      end
   end

   assign bus.busy_o         = r_busy;
   assign bus.digest_valid_o = r_dv;
   assign bus.digest_slot_o  = r_dslot;
   assign bus.digest_o       = r_digest;
endmodule

// File: tb/tb_sha256_compressor.sv
// tb_sha256_compressor: directed known-answer checks of the 4-slot compressor
module tb_sha256_compressor;
   localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic clk_i = 1'b0;
   logic rst_i;
   sha256_compressor_if bus ();
   sha256_compressor dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   int t_start = 0;
   logic [31:0] m [4][64];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // kind: 0 empty, 1 "abc", 2/3 first/second block of the 448-bit message
   task automatic load(input int s, input int kind);
      logic [7:0] c;
      for (int i = 0; i < 16; i++) m[s][i] = '0;
      case (kind)
         0: m[s][0] = 32'h80000000;
         1: begin m[s][0] = 32'h61626380; m[s][15] = 32'h00000018; end
         2: begin
            for (int i = 0; i < 14; i++) begin
               c = 8'h61 + 8'(i);
               m[s][i] = {c, c + 8'd1, c + 8'd2, c + 8'd3};
            end
            m[s][14] = 32'h80000000;
         end
         default: m[s][15] = 32'h000001c0;
      endcase
      for (int t = 16; t < 64; t++)
         m[s][t] = (ror(m[s][t-2], 17) ^ ror(m[s][t-2], 19) ^ (m[s][t-2] >> 10)) + m[s][t-7]
                 + (ror(m[s][t-15], 7) ^ ror(m[s][t-15], 18) ^ (m[s][t-15] >> 3)) + m[s][t-16];
   endtask

   task automatic start_blk(input bit chain, input bit junk);
      bus.start_i   = 1'b1;
      bus.chain_i   = chain;
      bus.w_valid_i = junk;
      bus.w_i       = 32'hdeadbeef;
      t_start       = cyc;
      @(negedge clk_i);
      bus.start_i   = 1'b0;
      bus.w_valid_i = 1'b0;
      chk("busy_after_start", 256'(bus.busy_o), 256'd1);
   endtask

   task automatic feed(input int gap_pct, input int start_at, input int rst_at);
      for (int n = 0; n < 256; n++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            bus.w_valid_i = 1'b0;
            bus.w_i       = $urandom;
            @(negedge clk_i);
            chk("busy_in_gap", 256'({bus.busy_o, bus.digest_valid_o}), 256'd2);
         end
         if (n == rst_at) begin
            rst_i         = 1'b1;
            bus.w_valid_i = 1'b1;
            bus.w_i       = m[n & 3][n >> 2];
            @(negedge clk_i);
            rst_i         = 1'b0;
            bus.w_valid_i = 1'b0;
            return;
         end
         bus.w_valid_i = 1'b1;
         bus.w_i       = m[n & 3][n >> 2];
         bus.start_i   = (n == start_at);
         @(negedge clk_i);
         bus.start_i   = 1'b0;
         if (n == start_at) chk("busy_after_poke", 256'(bus.busy_o), 256'd1);
      end
      bus.w_valid_i = 1'b0;
   endtask

   task automatic collect(input logic [255:0] e0, input logic [255:0] e1, input logic [255:0] e2,
                          input logic [255:0] e3, input int exp_lat, input bit poke, input bit chk_d);
      logic [255:0] e [4];
      int k;
      e = '{e0, e1, e2, e3};
      k = 0;
      while (!bus.digest_valid_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      chk("dv_timeout", 256'(bus.digest_valid_o), 256'd1);
      if (exp_lat > 0) chk("latency", 256'(cyc - t_start), 256'(exp_lat));
      for (int f = 0; f < 4; f++) begin
         chk("dv", 256'(bus.digest_valid_o), 256'd1);
         chk("slot", 256'(bus.digest_slot_o), 256'(f));
         chk("busy_final", 256'(bus.busy_o), 256'(f < 3));
         if (chk_d) chk($sformatf("digest%0d", f), bus.digest_o, e[f]);
         bus.start_i = poke && f == 0;
         bus.chain_i = 1'b0;
         @(negedge clk_i);
         bus.start_i = 1'b0;
      end
      chk("dv_drop", 256'({bus.digest_valid_o, bus.busy_o}), 256'd0);
   endtask

   initial begin
      rst_i         = 1'b1;
      bus.start_i   = 1'b0;
      bus.chain_i   = 1'b0;
      bus.w_valid_i = 1'b0;
      bus.w_i       = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_busy", 256'(bus.busy_o), 256'd0);
      chk("rst_dv", 256'(bus.digest_valid_o), 256'd0);
      chk("rst_slot", 256'(bus.digest_slot_o), 256'd0);
      chk("rst_digest", bus.digest_o, 256'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      for (int s = 0; s < 4; s++) load(s, 1);
      start_blk(1'b0, 1'b0);
      feed(0, -1, -1);
      collect(D_ABC, D_ABC, D_ABC, D_ABC, 258, 1'b0, 1'b1);

      load(0, 0); load(1, 1); load(2, 0); load(3, 0);
      start_blk(1'b0, 1'b1);
      feed(0, -1, -1);
      collect(D_EMPTY, D_ABC, D_EMPTY, D_EMPTY, 258, 1'b0, 1'b1);

      for (int s = 0; s < 4; s++) load(s, 2);
      start_blk(1'b0, 1'b0);
      feed(0, -1, -1);
      collect(D_TWO, D_TWO, D_TWO, D_TWO, 258, 1'b0, 1'b0);
      for (int s = 0; s < 4; s++) load(s, 3);
      start_blk(1'b1, 1'b0);
      feed(0, -1, -1);
      collect(D_TWO, D_TWO, D_TWO, D_TWO, 258, 1'b0, 1'b1);

      for (int s = 0; s < 4; s++) load(s, 1);
      start_blk(1'b0, 1'b1);
      feed(30, -1, -1);
      collect(D_ABC, D_ABC, D_ABC, D_ABC, 0, 1'b0, 1'b1);

      start_blk(1'b0, 1'b0);
      feed(0, 100, -1);
      collect(D_ABC, D_ABC, D_ABC, D_ABC, 258, 1'b1, 1'b1);

      start_blk(1'b0, 1'b0);
      feed(0, -1, 137);
      chk("abort_busy", 256'(bus.busy_o), 256'd0);
      chk("abort_dv", 256'(bus.digest_valid_o), 256'd0);
      chk("abort_digest", bus.digest_o, 256'd0);
      repeat (5) @(negedge clk_i);
      chk("abort_no_digest", 256'({bus.digest_valid_o, bus.busy_o}), 256'd0);
      start_blk(1'b0, 1'b0);
      feed(0, -1, -1);
      collect(D_ABC, D_ABC, D_ABC, D_ABC, 258, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
